// File: rtl/store_buffer.sv
// store_buffer
// In-order buffer of SW stores sitting between execution and the data-memory
// write port. Stores enter speculatively. Each handshake on the commit channel
// marks the oldest uncommitted store as committed. Only committed stores drain
// to memory. A flush discards every uncommitted store. The buffer also gives
// combinational store-to-load forwarding from the youngest matching entry.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset (clears all)
//   flush                   drop uncommitted entries, keep committed ones
//   st_valid/st_ready       enqueue handshake, st_addr/st_data payload
//   commit_valid/ready      commit handshake from the commit ring
//   mem_valid/mem_ready     drain handshake, mem_addr/mem_data = head entry
//   ld_addr -> ld_hit/ld_data  forwarding lookup over live entries
//   empty, count            occupancy (count = 0 .. 2**SB_WIDTH)
module store_buffer #(
  parameter int SB_WIDTH = 3,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic                commit_valid,
  output logic                commit_ready,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_hit,
  output logic [DATA_W-1:0]   ld_data,
  output logic                empty,
  output logic [SB_WIDTH:0]   count
);

  localparam int DEPTH = 1 << SB_WIDTH;

  // Ring pointers carry one extra wrap bit so full and empty differ.
  // Entries in [head, cmt) are committed; entries in [cmt, tail) are speculative.
  logic [SB_WIDTH:0] head_reg, cmt_reg, tail_reg;
  logic [SB_WIDTH:0] cmt_next;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic full;
  logic st_fire, cmt_fire, mem_fire;

  assign count = tail_reg - head_reg;
  assign full  = (count == (SB_WIDTH+1)'(DEPTH));
  assign empty = (head_reg == tail_reg);

  // Use this cycle's full flag. A drain in the same cycle does not free a
  // slot for an enqueue until the next cycle.
  assign st_ready     = !full && !flush;
  assign commit_ready = (cmt_reg != tail_reg);
  assign mem_valid    = (head_reg != cmt_reg);

  assign st_fire  = st_valid && st_ready;
  assign cmt_fire = commit_valid && commit_ready;
  assign mem_fire = mem_valid && mem_ready;

  // The head entry changes only when head advances, so the payload stays
  // stable while the memory port stalls.
  assign mem_addr = addr_mem[head_reg[SB_WIDTH-1:0]];
  assign mem_data = data_mem[head_reg[SB_WIDTH-1:0]];

  assign cmt_next = cmt_reg + {{SB_WIDTH{1'b0}}, cmt_fire};

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg <= '0;
      cmt_reg  <= '0;
      tail_reg <= '0;
    end else begin
      if (mem_fire)
        head_reg <= head_reg + 1'b1;
      cmt_reg <= cmt_next;
      // A flush truncates the ring just past the last committed entry. That
      // includes an entry committed in this same cycle. Enqueue is already
      // blocked through st_ready.
      if (flush)
        tail_reg <= cmt_next;
      else if (st_fire)
        tail_reg <= tail_reg + 1'b1;
    end
  end

  // The payload arrays are not reset. The pointers alone define liveness.
  always_ff @(posedge clk) begin
    if (st_fire) begin
      addr_mem[tail_reg[SB_WIDTH-1:0]] <= st_addr;
      data_mem[tail_reg[SB_WIDTH-1:0]] <= st_data;
    end
  end

  // Forwarding: offset gi counts from head. An offset is live when it is
  // below count. The highest live matching offset is the youngest store.
  logic [DEPTH-1:0]    fwd_match;
  logic [SB_WIDTH-1:0] fwd_slot [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    assign fwd_slot[gi]  = head_reg[SB_WIDTH-1:0] + SB_WIDTH'(gi);
    assign fwd_match[gi] = (count > (SB_WIDTH+1)'(gi)) &&
                           (addr_mem[fwd_slot[gi]] == ld_addr);
  end

  assign ld_hit = |fwd_match;

  always_comb begin
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_match[i])
        ld_data = data_mem[fwd_slot[i]];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int SB_WIDTH = 3;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 1 << SB_WIDTH;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic              commit_valid = 1'b0;
  logic              commit_ready;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              empty;
  logic [SB_WIDTH:0] count;

  store_buffer #(.SB_WIDTH(SB_WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: stores in program order. The first cmt_n entries are committed.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t sb_q[$];
  int     cmt_n = 0;
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational outputs against the model, then advance the model to
  // match the coming rising edge.
  task automatic step(input bit sv, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input bit cv, input bit mr, input bit fl, input logic [ADDR_W-1:0] la);
    bit     e_hit;
    logic [DATA_W-1:0] e_data;
    bit     st_f, c_f, m_f;
    int     new_cmt;
    entry_t e;
    @(negedge clk);
    st_valid = sv; st_addr = a; st_data = d;
    commit_valid = cv; mem_ready = mr; flush = fl; ld_addr = la;
    #1;
    check("count", 64'(count), 64'(sb_q.size()));
    check("empty", 64'(empty), 64'(sb_q.size() == 0));
    check("st_ready", 64'(st_ready), 64'(sb_q.size() < DEPTH && !fl));
    check("commit_ready", 64'(commit_ready), 64'(cmt_n < sb_q.size()));
    check("mem_valid", 64'(mem_valid), 64'(cmt_n > 0));
    if (cmt_n > 0) begin
      check("mem_addr", 64'(mem_addr), 64'(sb_q[0].a));
      check("mem_data", 64'(mem_data), 64'(sb_q[0].d));
    end
    e_hit = 1'b0; e_data = '0;
    for (int i = 0; i < sb_q.size(); i++)
      if (sb_q[i].a == la) begin e_hit = 1'b1; e_data = sb_q[i].d; end
    check("ld_hit", 64'(ld_hit), 64'(e_hit));
    if (e_hit) check("ld_data", 64'(ld_data), 64'(e_data));

    st_f = sv && sb_q.size() < DEPTH && !fl;
    c_f  = cv && cmt_n < sb_q.size();
    m_f  = mr && cmt_n > 0;
    new_cmt = cmt_n + (c_f ? 1 : 0);
    if (m_f) begin
      $display("write addr=0x%0h data=0x%0h", sb_q[0].a, sb_q[0].d);
      void'(sb_q.pop_front());
      new_cmt--;
    end
    cmt_n = new_cmt;
    if (fl) while (sb_q.size() > cmt_n) void'(sb_q.pop_back());
    if (st_f) begin
      e.a = a; e.d = d;
      sb_q.push_back(e);
    end
    $display("cyc sv=%0b cv=%0b mr=%0b fl=%0b -> model size=%0d committed=%0d",
             sv, cv, mr, fl, sb_q.size(), cmt_n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b1; commit_valid = 1'b1; st_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; commit_valid = 1'b0; st_valid = 1'b0; mem_ready = 1'b0;
    sb_q.delete();
    cmt_n = 0;
    $display("reset applied");
  endtask

  task automatic enq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input bit cv, input bit mr, input bit fl, input logic [ADDR_W-1:0] la);
    step(1'b0, '0, '0, cv, mr, fl, la);
  endtask

  // Commit and drain until the model is empty, within a fixed cycle budget.
  task automatic drain_all();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 40) begin
      idle(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    idle(1'b0, 1'b0, 1'b0, '0);
    check("drain_done", 64'(empty), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    // In-order drain of two stores.
    enq(20'h10, 32'hA);
    enq(20'h11, 32'hB);
    idle(1'b1, 1'b0, 1'b0, '0);
    idle(1'b1, 1'b0, 1'b0, '0);
    idle(1'b0, 1'b1, 1'b0, '0);
    idle(1'b0, 1'b1, 1'b0, '0);
    idle(1'b0, 1'b0, 1'b0, '0);

    // Fill to full, then enqueue with st_valid held while committing and draining.
    for (int i = 0; i < DEPTH; i++) enq(20'h100 + 20'(i), 32'h1000 + 32'(i));
    step(1'b1, 20'h1FF, 32'h9999, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 20'h1FF, 32'h9999, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 20'h1FF, 32'h9999, 1'b0, 1'b0, 1'b0, 20'h1FF);
    idle(1'b0, 1'b0, 1'b0, 20'h1FF);
    drain_all();

    // Flush keeps only the committed entries.
    for (int i = 0; i < 4; i++) enq(20'h200 + 20'(i), 32'h2000 + 32'(i));
    idle(1'b1, 1'b0, 1'b0, '0);
    idle(1'b0, 1'b0, 1'b1, 20'h203);
    idle(1'b0, 1'b0, 1'b0, 20'h203);
    idle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) enq(20'h300 + 20'(i), 32'h3000 + 32'(i));
    idle(1'b1, 1'b0, 1'b0, '0);
    idle(1'b1, 1'b0, 1'b1, '0);
    idle(1'b0, 1'b0, 1'b0, 20'h302);
    drain_all();

    // Forwarding picks the youngest match.
    enq(20'h20, 32'd1);
    enq(20'h30, 32'd2);
    enq(20'h20, 32'd3);
    idle(1'b0, 1'b0, 1'b0, 20'h20);
    idle(1'b0, 1'b0, 1'b0, 20'h40);
    idle(1'b1, 1'b0, 1'b0, 20'h20);
    idle(1'b0, 1'b0, 1'b0, 20'h20);
    drain_all();
    idle(1'b0, 1'b0, 1'b0, 20'h20);

    // Memory backpressure holds the head entry stable.
    for (int i = 0; i < 3; i++) enq(20'h400 + 20'(i), 32'h4000 + 32'(i));
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1, 1'b0, '0);

    // Reset mid-operation beats flush, commit and enqueue.
    for (int i = 0; i < 5; i++) enq(20'h50 + 20'(i), 32'h5000 + 32'(i));
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 1'b0, 20'h50);
    do_reset();
    idle(1'b1, 1'b0, 1'b0, 20'h50);
    idle(1'b0, 1'b0, 1'b0, 20'h50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
